// File: rtl/f3_input_arbiter.sv
// f3_input_arbiter: round-robin 4-input packet arbiter with per-input fallthrough FIFOs.
// Define F3_ARB_PKT_COUNT_EN to build the per-input forwarded-packet counters.
module f3_input_arbiter #(
    parameter int DATA_WIDTH         = 64,
    parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int IN_FIFO_DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data_0,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_0,
    input  logic                  in_wr_0,
    output logic                  in_rdy_0,
    input  logic [DATA_WIDTH-1:0] in_data_1,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_1,
    input  logic                  in_wr_1,
    output logic                  in_rdy_1,
    input  logic [DATA_WIDTH-1:0] in_data_2,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_2,
    input  logic                  in_wr_2,
    output logic                  in_rdy_2,
    input  logic [DATA_WIDTH-1:0] in_data_3,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_3,
    input  logic                  in_wr_3,
    output logic                  in_rdy_3,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [31:0]           pkt_cnt_0,
    output logic [31:0]           pkt_cnt_1,
    output logic [31:0]           pkt_cnt_2,
    output logic [31:0]           pkt_cnt_3
);
    localparam int DEPTH = 2 ** IN_FIFO_DEPTH_BITS;
    localparam int AW    = IN_FIFO_DEPTH_BITS;
    localparam int WW    = DATA_WIDTH + CTRL_WIDTH;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t                state, state_next;
    logic [WW-1:0]         wdata [4];
    logic [WW-1:0]         mem   [4][DEPTH];
    logic [AW-1:0]         wptr  [4];
    logic [AW-1:0]         rptr  [4];
    logic [AW:0]           cnt   [4];
    logic [3:0]            wr, wr_ok, rd, empty, full, rdy;
    logic [1:0]            rr_ptr, grant, sel;
    logic                  found, read_en, eop;
    logic [WW-1:0]         head;
    logic [CTRL_WIDTH-1:0] head_ctrl;

    assign wdata[0] = {in_ctrl_0, in_data_0};
    assign wdata[1] = {in_ctrl_1, in_data_1};
    assign wdata[2] = {in_ctrl_2, in_data_2};
    assign wdata[3] = {in_ctrl_3, in_data_3};
    assign wr       = {in_wr_3, in_wr_2, in_wr_1, in_wr_0};
    assign wr_ok    = wr & ~full;
    assign rd       = {3'b0, read_en} << grant;
    assign {in_rdy_3, in_rdy_2, in_rdy_1, in_rdy_0} = rdy;

    always_comb begin
        empty = '0;
        full  = '0;
        rdy   = '0;
        for (int i = 0; i < 4; i++) begin
            empty[i] = cnt[i] == '0;
            full[i]  = int'(cnt[i]) == DEPTH;
            rdy[i]   = int'(cnt[i]) < DEPTH - 1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end else begin
                if (wr_ok[i]) begin
                    mem[i][wptr[i]] <= wdata[i];
                    wptr[i]         <= wptr[i] + 1'b1;
                end
                if (rd[i])
                    rptr[i] <= rptr[i] + 1'b1;
                cnt[i] <= cnt[i] + {{AW{1'b0}}, wr_ok[i]} - {{AW{1'b0}}, rd[i]};
            end
        end
    end

    assign head      = mem[grant][rptr[grant]];
    assign head_ctrl = head[WW-1 -: CTRL_WIDTH];

    // first non-empty input at or after rr_ptr; lowest offset wins
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (!empty[rr_ptr + 2'(k)]) begin
                sel   = rr_ptr + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found)
                grant <= sel;
            if (eop)
                rr_ptr <= grant + 1'b1;
        end
    end

    always_comb begin
        state_next = (state == IDLE && found)                      ? HDR     :
                     (state == HDR && read_en && head_ctrl == '0)  ? PAYLOAD :
                     eop                                           ? IDLE    : state;
    end

    always_comb begin
        read_en = state != IDLE && out_rdy && !empty[grant];
        eop     = state == PAYLOAD && read_en && head_ctrl != '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= read_en;
            if (read_en)
                {out_ctrl, out_data} <= head;
        end
    end

`ifdef F3_ARB_PKT_COUNT_EN
    logic [31:0] pkt_cnt [4];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset)
                pkt_cnt[i] <= '0;
            else if (eop && grant == 2'(i))
                pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
        end
    end

    assign pkt_cnt_0 = pkt_cnt[0];
    assign pkt_cnt_1 = pkt_cnt[1];
    assign pkt_cnt_2 = pkt_cnt[2];
    assign pkt_cnt_3 = pkt_cnt[3];
`else
    assign pkt_cnt_0 = '0;
    assign pkt_cnt_1 = '0;
    assign pkt_cnt_2 = '0;
    assign pkt_cnt_3 = '0;
`endif
endmodule
